div_unit: RTL and testbench

//  Multi-cycle 32-bit integer divider in the EX stage, downstream of the ALU decoder.

---
 rtl/div_unit_pkg.sv | 21 ++
 rtl/div_step.sv | 25 ++
 rtl/div_unit.sv | 132 +++++++++++++
 tb/tb_div_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage integer divider: ALU op codes that
// select the divider and the controller state type.
package div_unit_pkg;

  // Decoded ALU op codes that the ALU decoder produces for DIV / DIVU.
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // True when the decoded op is handled by the divider.
  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left by one,
// trial-subtract the divisor and keep the difference when it does not borrow.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_part;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;

  // Partial remainder is one bit wider than the divisor before the compare.
  assign w_part = {i_rem, i_quo[WIDTH-1]};
  assign w_ge   = (w_part >= {1'b0, i_div});
  // When w_ge holds the difference is below the divisor, so WIDTH bits suffice.
  assign w_sub  = w_part[WIDTH-1:0] - i_div;
  assign o_rem  = w_ge ? w_sub : w_part[WIDTH-1:0];
  assign o_quo  = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage. Stalls the pipeline while a
// divide is in flight and returns hi=remainder, lo=quotient with a ready pulse.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       alucontrolE,
  input  logic             validE,
  input  logic             flushE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic             stallE,
  output logic             ready,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_ready;

  logic             w_start;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo;

  assign w_start  = validE & is_div_op(alucontrolE) & ~flushE;
  assign w_signed = (alucontrolE == EXE_DIV_OP);
  assign w_a_neg  = w_signed & srcaE[WIDTH-1];
  assign w_b_neg  = w_signed & srcbE[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -srcaE : srcaE;
  assign w_b_mag  = w_b_neg ? -srcbE : srcbE;

  assign stallE = w_start & (r_state != DIV_DONE);
  assign ready  = r_ready;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem),
    .o_quo (w_quo)
  );

  // Divider controller: operand capture, iteration, result registration.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= DIV_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        DIV_IDLE: begin
          if (w_start) begin
            r_cnt <= '0;
            r_rem <= '0;
            if (srcbE == '0) begin
              // Dividend parked in r_quo; it becomes hi on divide-by-zero.
              r_quo   <= srcaE;
              r_state <= DIV_ZERO;
            end else begin
              r_quo    <= w_a_mag;
              r_div    <= w_b_mag;
              r_sign_q <= w_a_neg ^ w_b_neg;
              r_sign_r <= w_a_neg;
              r_state  <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          if (flushE) begin
            r_state <= DIV_IDLE;
          end else begin
            r_rem <= w_rem;
            r_quo <= w_quo;
            r_cnt <= r_cnt + 1'b1;
            // Sign fixup is applied to the final step's output so the
            // result registers are valid in the same cycle as DONE/ready.
            if (r_cnt == LAST_STEP) begin
              r_hi    <= r_sign_r ? -w_rem : w_rem;
              r_lo    <= r_sign_q ? -w_quo : w_quo;
              r_ready <= 1'b1;
              r_state <= DIV_DONE;
            end
          end
        end
        DIV_ZERO: begin
          if (flushE) begin
            r_state <= DIV_IDLE;
          end else begin
            r_hi    <= r_quo;
            r_lo    <= '1;
            r_ready <= 1'b1;
            r_state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          r_state <= DIV_IDLE;
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  alucontrolE;
  logic        validE;
  logic        flushE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        stallE;
  logic        ready;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  // Expected DUT outputs for the current cycle, maintained by the driver.
  logic        m_stall;
  logic        m_ready;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        chk_en;
  logic        len_chk_en;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_run = 0;
  bit pinned = 1'b0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .alucontrolE (alucontrolE),
    .validE      (validE),
    .flushE      (flushE),
    .srcaE       (srcaE),
    .srcbE       (srcbE),
    .stallE      (stallE),
    .ready       (ready),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  // Reference: returns {hi=remainder, lo=quotient} straight from arithmetic.
  function automatic logic [63:0] ref_div(input bit is_signed, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!is_signed) begin
      uq = a / b;
      ur = a % b;
      return {ur, uq};
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Single compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (!pinned) begin
      pinned = 1'b1;
      check("pin_divu_100_7", ref_div(0, 32'd100, 32'd7) == {32'd2, 32'd14}, 32'd1);
      check("pin_div_m7_2", ref_div(1, 32'hFFFF_FFF9, 32'd2) == {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 32'd1);
      check("pin_div_7_m2", ref_div(1, 32'd7, 32'hFFFF_FFFE) == {32'd1, 32'hFFFF_FFFD}, 32'd1);
      check("pin_div_ovf", ref_div(1, 32'h8000_0000, 32'hFFFF_FFFF) == {32'd0, 32'h8000_0000}, 32'd1);
      check("pin_divu_5_0", ref_div(0, 32'd5, 32'd0) == {32'd5, 32'hFFFF_FFFF}, 32'd1);
    end
    if (chk_en) begin
      check("stallE", {31'd0, stallE}, {31'd0, m_stall});
      check("ready", {31'd0, ready}, {31'd0, m_ready});
      check("hi_o", hi_o, m_hi);
      check("lo_o", lo_o, m_lo);
      if (stallE) stall_run++;
      else begin
        if (len_chk_en && stall_run != 0) check("stall_len", stall_run, 32'd33);
        stall_run = 0;
      end
    end
  end

  // Issue one divide; optionally flush or reset at a given busy cycle.
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int flush_at, input int rst_at);
    int lat;
    @(posedge clk); #1;
    validE = 1'b1; alucontrolE = op; srcaE = a; srcbE = b; flushE = 1'b0;
    m_ready = 1'b0; m_stall = 1'b1;
    lat = (b == 32'd0) ? 2 : 33;
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      srcaE = $urandom; srcbE = $urandom;
      if (c == flush_at) begin
        flushE = 1'b1; m_stall = 1'b0;
        @(posedge clk); #1;
        flushE = 1'b0; validE = 1'b0;
        return;
      end
      if (c == rst_at) begin
        resetn = 1'b0; validE = 1'b0;
        m_stall = 1'b0; m_ready = 1'b0; m_hi = '0; m_lo = '0;
        @(posedge clk); #1;
        resetn = 1'b1;
        return;
      end
      if (c == lat) begin
        m_stall = 1'b0; m_ready = 1'b1;
        m_hi = exp[63:32]; m_lo = exp[31:0];
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      validE = 1'b0; flushE = 1'b0;
      m_ready = 1'b0; m_stall = 1'b0;
    end
  endtask

  // Live non-divide instructions must never stall.
  task automatic nondiv(input int n);
    logic [7:0] op;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      do op = 8'($urandom); while (is_div_op(op));
      validE = 1'b1; flushE = 1'b0; alucontrolE = op;
      srcaE = $urandom; srcbE = $urandom;
      m_ready = 1'b0; m_stall = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a, b;
    bit          sgn;
    resetn = 1'b0; validE = 1'b0; flushE = 1'b0; alucontrolE = '0;
    srcaE = '0; srcbE = '0;
    m_stall = 1'b0; m_ready = 1'b0; m_hi = '0; m_lo = '0;
    chk_en = 1'b0; len_chk_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1 resetn = 1'b1;

    len_chk_en = 1'b1;
    run_div(EXE_DIVU_OP, 32'd100, 32'd7, {32'd2, 32'd14}, -1, -1);
    idle(2);
    len_chk_en = 1'b0;
    run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, -1, -1);
    run_div(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, -1, -1);
    run_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, -1, -1);
    run_div(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, -1, -1);
    run_div(EXE_DIVU_OP, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, -1, -1);
    idle(1);
    run_div(EXE_DIVU_OP, 32'd1000, 32'd3, 64'd0, 10, -1);
    idle(2);
    run_div(EXE_DIVU_OP, 32'd9, 32'd3, {32'd0, 32'd3}, -1, -1);
    nondiv(5);
    run_div(EXE_DIV_OP, 32'd12345, 32'd17, 64'd0, -1, 20);
    idle(2);
    run_div(EXE_DIV_OP, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, -1, -1);

    for (int t = 0; t < 40; t++) begin
      sgn = 1'($urandom);
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = $urandom_range(0, 5000);
        2: a = -$urandom_range(0, 5000);
        default: a = 32'h8000_0000 ^ $urandom_range(0, 3);
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom;
        2: b = -$urandom_range(1, 300);
        3: b = 32'hFFFF_FFFF;
        default: b = $urandom_range(1, 300);
      endcase
      run_div(sgn ? EXE_DIV_OP : EXE_DIVU_OP, a, b, ref_div(sgn, a, b), -1, -1);
      if ($urandom_range(0, 2) == 0) nondiv($urandom_range(1, 3));
    end
    idle(3);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
